// File: rtl/fp_mult_arbiter.sv
// Round-robin front end for one shared single-precision multiplier: picks one
// requester per cycle, registers its operands and carries its ID to the product.
module fp_mult_arbiter #(
  parameter int N       = 4,
  parameter int MUL_LAT = 1,
  parameter int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic [31:0]       mul_dataa,
  output logic [31:0]       mul_datab,
  input  logic [31:0]       mul_result,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic [31:0]       op_count
);

  // Handshake: requester i transfers an operand pair in any cycle where
  // req_valid[i] && req_ready[i]. req_valid must not depend on req_ready and
  // must hold, with its operands, until that cycle. rsp_valid has no ready.

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]    dataa_q, dataa_d;
  logic [31:0]    datab_q, datab_d;
  logic [31:0]    op_count_q, op_count_d;
  logic           iss_vld_q, iss_vld_d;
  logic [IDW-1:0] iss_id_q, iss_id_d;
  logic [MUL_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [IDW-1:0]     pipe_id_q [MUL_LAT];
  logic [IDW-1:0]     pipe_id_d [MUL_LAT];
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_data_q, rsp_data_d;

  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  int             cand;
  logic [IDW-1:0] cand_idx;

  // Search starts just after the last winner, so the last winner ranks lowest.
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr_q;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDW'(cand);
      if (en && !grant_any && req_valid[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_any       = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    dataa_d    = dataa_q;
    datab_d    = datab_q;
    op_count_d = op_count_q;
    iss_vld_d  = grant_any;
    iss_id_d   = grant_idx;
    if (grant_any) begin
      rr_ptr_d   = grant_idx;
      dataa_d    = sel_a;
      datab_d    = sel_b;
      op_count_d = op_count_q + 32'd1;
    end
  end

  // Tag shift register mirrors the multiplier depth and never stalls.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_id_d     = pipe_id_q;
    pipe_vld_d[0] = iss_vld_q;
    pipe_id_d[0]  = iss_id_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = pipe_vld_q[MUL_LAT-1];
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (pipe_vld_q[MUL_LAT-1]) begin
      rsp_id_d   = pipe_id_q[MUL_LAT-1];
      rsp_data_d = mul_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= IDW'(N - 1);
      dataa_q     <= '0;
      datab_q     <= '0;
      op_count_q  <= '0;
      iss_vld_q   <= 1'b0;
      iss_id_q    <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < MUL_LAT; i++) pipe_id_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      dataa_q     <= dataa_d;
      datab_q     <= datab_d;
      op_count_q  <= op_count_d;
      iss_vld_q   <= iss_vld_d;
      iss_id_q    <= iss_id_d;
      pipe_vld_q  <= pipe_vld_d;
      for (int i = 0; i < MUL_LAT; i++) pipe_id_q[i] <= pipe_id_d[i];
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = grant;
  assign mul_dataa = dataa_q;
  assign mul_datab = datab_q;
  assign op_count  = op_count_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: a 4-requester MUL_LAT=1 instance checked against a
// queue-based model, plus a MUL_LAT=3 instance for the latency case.
module tb_fp_mult_arbiter;
  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int IDW = 2;

  logic clk, rst_n;
  logic en, en3;
  logic [N-1:0] req_valid, req_ready, rv3, rr3;
  logic [32*N-1:0] req_a, req_b, ra3, rb3;
  logic [31:0] mul_dataa, mul_datab, mul_result, rsp_data, op_count;
  logic [31:0] md3a, md3b, mr3, rsp3d, oc3;
  logic rsp_valid, rsp3v;
  logic [IDW-1:0] rsp_id, rsp3id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  int m_last;
  logic [31:0] m_cnt, m_a;
  logic [IDW+31:0] exp_q[$];
  int due_q[$];

  fp_mult_arbiter #(.N(N), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .mul_dataa(mul_dataa),
    .mul_datab(mul_datab), .mul_result(mul_result), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .op_count(op_count));

  fp_mult_arbiter #(.N(N), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .req_valid(rv3), .req_a(ra3),
    .req_b(rb3), .req_ready(rr3), .mul_dataa(md3a), .mul_datab(md3b),
    .mul_result(mr3), .rsp_valid(rsp3v), .rsp_id(rsp3id), .rsp_data(rsp3d),
    .op_count(oc3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Truncating single-precision multiply with zero flush.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    logic s;
    int e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e++; end
    else m = p[45:23];
    if (e <= 0) return 32'h0;
    if (e >= 255) return {s, 8'hff, 23'h0};
    return {s, e[7:0], m};
  endfunction

  logic [31:0] mp1 [LAT];
  logic [31:0] mp3 [3];
  always @(posedge clk) begin
    mp1[0] <= fmul(mul_dataa, mul_datab);
    for (int i = 1; i < LAT; i++) mp1[i] <= mp1[i-1];
    mp3[0] <= fmul(md3a, md3b);
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign mul_result = mp1[LAT-1];
  assign mr3 = mp3[2];

  function automatic logic [31:0] rand_fp();
    if ($urandom_range(0, 9) == 0) return 32'h0;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
  endfunction

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    en3 = 1'b0; rv3 = '0; ra3 = '0; rb3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1; m_cnt = 0; m_a = 0;
    exp_q.delete(); due_q.delete();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Reference: expected outputs for the current cycle, then the effect of any grant.
  task automatic model_eval(output logic [N-1:0] e_ready, output logic e_rv,
                            output logic [IDW-1:0] e_id, output logic [31:0] e_data,
                            output logic [31:0] e_a, output logic [31:0] e_cnt);
    int g;
    g = -1;
    e_a = m_a; e_cnt = m_cnt; e_ready = '0; e_rv = 1'b0; e_id = '0; e_data = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e_rv = 1'b1;
      {e_id, e_data} = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    if (en)
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      m_last = g;
      m_cnt = m_cnt + 1;
      m_a = req_a[32*g +: 32];
      exp_q.push_back({IDW'(g), fmul(req_a[32*g +: 32], req_b[32*g +: 32])});
      due_q.push_back(cyc + 2 + LAT);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; en3 = 1'b0; rv3 = '0;
    #3;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, op_count, mul_dataa, mul_datab} !== '0) begin
      errors++;
      $display("FAIL reset_values: got v=%b id=%0d d=%h cnt=%0d a=%h b=%h, required all zero",
               rsp_valid, rsp_id, rsp_data, op_count, mul_dataa, mul_datab);
    end
    checks++;
    if ({rsp3v, oc3} !== '0) begin
      errors++;
      $display("FAIL reset_lat3: got v=%b cnt=%0d, required 0", rsp3v, oc3);
    end
    do_reset();
    en = 1'b1; req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b required 0001", req_ready);
    end
    @(posedge clk); #1; cyc++;
    req_valid = '0;
  endtask

  task automatic test_single_op();
    do_reset();
    en = 1'b1; req_valid = 4'b0100;
    set_ops(2, 32'h40000000, 32'h40400000);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++; $display("FAIL single_ready: got %b required 0100", req_ready);
        end
      end
      if (k == 1) begin
        checks++;
        if (mul_dataa !== 32'h40000000 || mul_datab !== 32'h40400000) begin
          errors++; $display("FAIL single_mul_ops: got %h %h required 40000000 40400000", mul_dataa, mul_datab);
        end
      end
      checks++;
      if (rsp_valid !== (k == 3)) begin
        errors++; $display("FAIL single_rsp_valid k=%0d: got %b required %b", k, rsp_valid, k == 3);
      end
      if (k == 3) begin
        checks++;
        if (rsp_id !== 2'd2 || rsp_data !== 32'h40C00000 || op_count !== 32'd1) begin
          errors++;
          $display("FAIL single_rsp: got id=%0d d=%h cnt=%0d required id=2 d=40c00000 cnt=1", rsp_id, rsp_data, op_count);
        end
      end
      @(posedge clk); #1; cyc++;
      req_valid = '0;
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e_ready; logic e_rv; logic [IDW-1:0] e_id; logic [31:0] e_data, e_a, e_cnt;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, rand_fp(), rand_fp());
    for (int k = 0; k < 14; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      model_eval(e_ready, e_rv, e_id, e_data, e_a, e_cnt);
      if (k < 8) begin
        checks++;
        if (req_ready !== 4'(1 << (k % 4))) begin
          errors++; $display("FAIL rr_rotation k=%0d: got %b required %b", k, req_ready, 4'(1 << (k % 4)));
        end
      end
      if (k >= 3 && k <= 10) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'((k - 3) % 4)) begin
          errors++; $display("FAIL rr_rsp_seq k=%0d: got v=%b id=%0d required v=1 id=%0d", k, rsp_valid, rsp_id, (k - 3) % 4);
        end
      end
      checks++;
      if (req_ready !== e_ready || rsp_valid !== e_rv || op_count !== e_cnt || mul_dataa !== e_a) begin
        errors++;
        $display("FAIL rr_model cyc=%0d: got rdy=%b v=%b cnt=%0d a=%h required rdy=%b v=%b cnt=%0d a=%h",
                 cyc, req_ready, rsp_valid, op_count, mul_dataa, e_ready, e_rv, e_cnt, e_a);
      end
      if (e_rv) begin
        checks++;
        if (rsp_id !== e_id || rsp_data !== e_data) begin
          errors++; $display("FAIL rr_rsp_data cyc=%0d: got %0d/%h required %0d/%h", cyc, rsp_id, rsp_data, e_id, e_data);
        end
      end
      @(posedge clk); #1; cyc++;
      for (int i = 0; i < N; i++) if (e_ready[i]) set_ops(i, rand_fp(), rand_fp());
    end
  endtask

  task automatic test_zero_operand();
    do_reset();
    en = 1'b1; req_valid = 4'b0001;
    set_ops(0, 32'h00000000, 32'h3F800000);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
          errors++; $display("FAIL zero_operand: got v=%b id=%0d d=%h required v=1 id=0 d=00000000", rsp_valid, rsp_id, rsp_data);
        end
      end
      @(posedge clk); #1; cyc++;
      req_valid = '0;
    end
  endtask

  task automatic test_en_gating();
    logic [N-1:0] e_ready, cur; logic e_rv; logic [IDW-1:0] e_id; logic [31:0] e_data, e_a, e_cnt;
    do_reset();
    cur = 4'b1010;
    set_ops(1, rand_fp(), rand_fp());
    set_ops(3, rand_fp(), rand_fp());
    for (int k = 0; k < 10; k++) begin
      en = (k >= 3);
      req_valid = cur;
      @(negedge clk);
      model_eval(e_ready, e_rv, e_id, e_data, e_a, e_cnt);
      if (k < 3) begin
        checks++;
        if (req_ready !== 4'b0000) begin
          errors++; $display("FAIL en_low_ready k=%0d: got %b required 0000", k, req_ready);
        end
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (req_ready !== ((k == 3) ? 4'b0010 : 4'b1000)) begin
          errors++; $display("FAIL en_grant_order k=%0d: got %b", k, req_ready);
        end
      end
      if (k == 6 || k == 7) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== ((k == 6) ? 2'd1 : 2'd3)) begin
          errors++; $display("FAIL en_rsp k=%0d: got v=%b id=%0d", k, rsp_valid, rsp_id);
        end
      end
      checks++;
      if (req_ready !== e_ready || rsp_valid !== e_rv || (e_rv && {rsp_id, rsp_data} !== {e_id, e_data})) begin
        errors++;
        $display("FAIL en_model cyc=%0d: got rdy=%b v=%b id=%0d d=%h required rdy=%b v=%b id=%0d d=%h",
                 cyc, req_ready, rsp_valid, rsp_id, rsp_data, e_ready, e_rv, e_id, e_data);
      end
      cur = cur & ~e_ready;
      @(posedge clk); #1; cyc++;
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    en = 1'b1; req_valid = 4'b0011;
    set_ops(0, rand_fp(), rand_fp());
    set_ops(1, rand_fp(), rand_fp());
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== ((k == 0) ? 4'b0001 : 4'b0010)) begin
        errors++; $display("FAIL midrst_accept k=%0d: got %b", k, req_ready);
      end
      @(posedge clk); #1; cyc++;
    end
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1; cyc++;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== 32'd0) begin
        errors++; $display("FAIL midrst_no_rsp k=%0d: got v=%b cnt=%0d required v=0 cnt=0", k, rsp_valid, op_count);
      end
    end
    @(posedge clk); #1; cyc++;
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL midrst_next_grant: got %b required 0010", req_ready);
    end
    @(posedge clk); #1; cyc++;
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] e_ready, cur; logic e_rv; logic [IDW-1:0] e_id; logic [31:0] e_data, e_a, e_cnt;
    do_reset();
    cur = '0;
    for (int c = 0; c < 400; c++) begin
      en = (c >= 380) || ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++)
        if (!cur[i] && c < 380 && $urandom_range(0, 2) != 0) begin
          cur[i] = 1'b1;
          set_ops(i, rand_fp(), rand_fp());
        end
      req_valid = cur;
      @(negedge clk);
      model_eval(e_ready, e_rv, e_id, e_data, e_a, e_cnt);
      checks++;
      if (req_ready !== e_ready || rsp_valid !== e_rv || op_count !== e_cnt || mul_dataa !== e_a) begin
        errors++;
        $display("FAIL rand_model cyc=%0d: got rdy=%b v=%b cnt=%0d a=%h required rdy=%b v=%b cnt=%0d a=%h",
                 cyc, req_ready, rsp_valid, op_count, mul_dataa, e_ready, e_rv, e_cnt, e_a);
      end
      if (e_rv) begin
        checks++;
        if (rsp_id !== e_id || rsp_data !== e_data) begin
          errors++; $display("FAIL rand_rsp cyc=%0d: got %0d/%h required %0d/%h", cyc, rsp_id, rsp_data, e_id, e_data);
        end
      end
      cur = cur & ~e_ready;
      @(posedge clk); #1; cyc++;
    end
    req_valid = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: %0d responses still outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_lat3();
    logic [31:0] a, b;
    do_reset();
    a = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
    b = {1'b1, 8'($urandom_range(100, 150)), 23'($urandom)};
    en3 = 1'b1; rv3 = 4'b0010;
    ra3[63:32] = a; rb3[63:32] = b;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (rr3 !== 4'b0010) begin
          errors++; $display("FAIL lat3_ready: got %b required 0010", rr3);
        end
      end
      if (k == 1) begin
        checks++;
        if (md3a !== a || md3b !== b) begin
          errors++; $display("FAIL lat3_ops: got %h %h required %h %h", md3a, md3b, a, b);
        end
      end
      checks++;
      if (rsp3v !== (k == 5)) begin
        errors++; $display("FAIL lat3_valid k=%0d: got %b required %b", k, rsp3v, k == 5);
      end
      if (k == 5) begin
        checks++;
        if (rsp3id !== 2'd1 || rsp3d !== fmul(a, b) || oc3 !== 32'd1) begin
          errors++; $display("FAIL lat3_rsp: got id=%0d d=%h cnt=%0d required id=1 d=%h cnt=1", rsp3id, rsp3d, oc3, fmul(a, b));
        end
      end
      @(posedge clk); #1; cyc++;
      rv3 = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    en3 = 1'b0; rv3 = '0; ra3 = '0; rb3 = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_zero_operand();
    test_en_gating();
    test_reset_mid_flight();
    test_random();
    test_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
